meduram_bist_agent: RTL and testbench
=====================================

Name: meduram_bist_agent

Overview:
Initiator-side agent for the multi-port RAM. It drives one write port (wren/wraddr/wrdata) and one read port (rden/rdaddr/rddata) of the top RAM. On start it fills an address range with a seed-derived pattern, reads the range back, and compares against expected data delayed to match the RAM read latency. It is used as an on-chip BIST engine and as a reusable traffic generator in concurrent multi-agent benches.

Parameters:
ADDR_WIDTH, 8, RAM address width
RAM_DEPTH, 2**ADDR_WIDTH, RAM depth in words (must equal 2**ADDR_WIDTH)
DATA_WIDTH, 32, RAM data width
RD_LATENCY, 1, cycles from rden/rdaddr sampled to rddata valid (1..4)
ERR_WIDTH, 16, error counter width

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle run request
seed  in  DATA_WIDTH  pattern seed, latched on accepted start
first_addr  in  ADDR_WIDTH  first address of range, latched on start
last_addr  in  ADDR_WIDTH  last address of range (inclusive), latched on start
busy  out  1  run in progress
done  out  1  level, high from run end until next accepted start
pass  out  1  valid when done: err_count == 0
err_count  out  ERR_WIDTH  saturating mismatch count for current/last run
err_addr  out  ADDR_WIDTH  address of first mismatch (optional feature)
err_data  out  DATA_WIDTH  rddata of first mismatch (optional feature)
wren  out  1  RAM write enable
wraddr  out  ADDR_WIDTH  RAM write address
wrdata  out  DATA_WIDTH  RAM write data
rden  out  1  RAM read enable
rdaddr  out  ADDR_WIDTH  RAM read address
rddata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (asynchronous, aresetn=0): state IDLE. busy, done, pass, wren, rden = 0. All addresses, data, err_count, err_addr and err_data = 0. The expected-data pipeline valid bits are cleared.
- Reset mid-operation aborts the run immediately. No further RAM accesses occur until a new start.
- States: IDLE, WRITE, READ, DRAIN, DONE. All outputs are registered.
- start is accepted only in IDLE or DONE. It is ignored in WRITE, READ and DRAIN.
- Accepted start at edge E0:
  - latch seed, first_addr, last_addr
  - clear err_count, err_addr, err_data
  - done=0, busy=1, go to WRITE.
- Range length N = (last_addr - first_addr + 1) mod 2**ADDR_WIDTH. N = 0 means the full RAM_DEPTH.
- Addresses increment modulo 2**ADDR_WIDTH. For example, first=0xFE, last=0x01 gives 0xFE, 0xFF, 0x00, 0x01.
- Pattern: data(addr) = seed XOR zero-extended addr.
- WRITE: wren=1 for exactly N consecutive cycles, following E0. One word per cycle, wraddr stepping through the range, wrdata = data(wraddr). After the last address, move to READ.
- READ: rden=1 for N consecutive cycles, starting the cycle after the last write, same address order. Each read pushes {valid, addr, data(addr)} into an RD_LATENCY-deep shift pipeline. After the last address, move to DRAIN.
- Compare: when a valid entry reaches the pipeline end, compare it against rddata in that cycle. On mismatch, err_count increments and saturates at all-ones.
- DRAIN: wren=rden=0. Stay until the pipeline holds no valid entries (RD_LATENCY cycles), then go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). All outputs hold until the next start.
- Timing: with start at E0, done rises at edge E0 + 2N + RD_LATENCY + 1.
- wren and rden are never high in the same cycle.

Optional Feature:
MEDURAM_AGENT_ERRLOG_EN.
- Defined: on the first mismatch of a run, capture the expected address into err_addr and the received rddata into err_data. Later mismatches do not update them. Both are cleared on accepted start.
- Undefined: err_addr and err_data are tied to 0 and no capture logic is built. The ports remain present either way.

Test Plan:
- Full range: first=0x00, last=0xFF, seed=0xA5A5A5A5, ideal RAM with RD_LATENCY=1 -> 256 writes (wrdata at 0x10 = 0xA5A5A5B5), 256 reads, done at E0+514, pass=1, err_count=0.
- Wrap range: first=0xFE, last=0x01, seed=0 -> wraddr sequence FE, FF, 00, 01, then the same sequence on rdaddr; pass=1, done at E0+10.
- Fault injection: bench flips bit 0 of rddata for address 0x10, seed=0x12345678 -> err_count=1, pass=0. With ERRLOG_EN: err_addr=0x10, err_data=0x12345669.
- Start while busy: pulse start during WRITE with a different seed -> ignored; the original seed pattern is completed and checked.
- Reset mid-WRITE: aresetn low at write 5 -> all outputs 0 immediately. A new start with first=0x20, last=0x2F then completes with pass=1.
- Saturation: ERR_WIDTH=4, every read corrupted over 256 words -> err_count=0xF, pass=0.

Source files
------------

// File: rtl/meduram_bist_agent.sv
// BIST / traffic agent for one write port and one read port of the multi-port RAM:
// fills a range with seed^addr, reads it back, counts mismatches. Optional: MEDURAM_AGENT_ERRLOG_EN.
module meduram_bist_agent #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_data,
    output logic                  wren,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic [DATA_WIDTH-1:0] wrdata,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   FULL_LEN = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   L_ONE    = 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = 1;
    localparam logic [ERR_WIDTH-1:0]  E_ONE    = 1;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] s,
                                                      input logic [ADDR_WIDTH-1:0] a);
        return s ^ DATA_WIDTH'(a);
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic [ADDR_WIDTH:0]   len_m1_q, len_m1_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  wren_q, wren_d, rden_q, rden_d;
    logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
    logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

    logic                  start_ok, mismatch;
    logic [ADDR_WIDTH:0]   len_raw, start_len_m1;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch = pipe_vld_q[RD_LATENCY-1] && (pipe_data_q[RD_LATENCY-1] != rddata);
    // A zero-length modulo result means the whole RAM.
    assign len_raw      = {1'b0, ADDR_WIDTH'(last_addr - first_addr + A_ONE)};
    assign start_len_m1 = ((len_raw == '0) ? FULL_LEN : len_raw) - L_ONE;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok)      state_d = S_WRITE;
            S_WRITE:        if (cnt_q == '0)   state_d = S_READ;
            S_READ:         if (cnt_q == '0)   state_d = S_DRAIN;
            S_DRAIN:        if (~|pipe_vld_q)  state_d = S_DONE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seed_d      = seed_q;
        first_d     = first_q;
        len_m1_d    = len_m1_q;
        cnt_d       = cnt_q;
        wren_d      = wren_q;
        wraddr_d    = wraddr_q;
        wrdata_d    = wrdata_q;
        rden_d      = rden_q;
        rdaddr_d    = rdaddr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        if (mismatch && err_count_q != '1)
            err_count_d = err_count_q + E_ONE;
        if (start_ok) begin
            seed_d      = seed;
            first_d     = first_addr;
            len_m1_d    = start_len_m1;
            cnt_d       = start_len_m1;
            wren_d      = 1'b1;
            wraddr_d    = first_addr;
            wrdata_d    = pattern(seed, first_addr);
            rden_d      = 1'b0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_count_d = '0;
        end else begin
            case (state_q)
                S_WRITE: begin
                    if (cnt_q == '0) begin
                        wren_d   = 1'b0;
                        rden_d   = 1'b1;
                        rdaddr_d = first_q;
                        cnt_d    = len_m1_q;
                    end else begin
                        wraddr_d = wraddr_q + A_ONE;
                        wrdata_d = pattern(seed_q, wraddr_q + A_ONE);
                        cnt_d    = cnt_q - L_ONE;
                    end
                end
                S_READ: begin
                    if (cnt_q == '0) begin
                        rden_d = 1'b0;
                    end else begin
                        rdaddr_d = rdaddr_q + A_ONE;
                        cnt_d    = cnt_q - L_ONE;
                    end
                end
                S_DRAIN: begin
                    if (~|pipe_vld_q) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (err_count_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seed_q      <= '0;
            first_q     <= '0;
            len_m1_q    <= '0;
            cnt_q       <= '0;
            wren_q      <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            rden_q      <= 1'b0;
            rdaddr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            seed_q      <= seed_d;
            first_q     <= first_d;
            len_m1_q    <= len_m1_d;
            cnt_q       <= cnt_d;
            wren_q      <= wren_d;
            wraddr_q    <= wraddr_d;
            wrdata_q    <= wrdata_d;
            rden_q      <= rden_d;
            rdaddr_q    <= rdaddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
        end
    end

    // Stage 0 loads on the edge the RAM samples rden/rdaddr, so the last stage lines up with rddata.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
        end else begin
            pipe_vld_q[0]  <= rden_q;
            pipe_data_q[0] <= pattern(seed_q, rdaddr_q);
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

`ifdef MEDURAM_AGENT_ERRLOG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic [DATA_WIDTH-1:0] err_data_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_addr_q[i] <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            pipe_addr_q[0] <= rdaddr_q;
            for (int i = 1; i < RD_LATENCY; i++) pipe_addr_q[i] <= pipe_addr_q[i-1];
            if (start_ok) begin
                err_addr_q <= '0;
                err_data_q <= '0;
            end else if (mismatch && err_count_q == '0) begin
                err_addr_q <= pipe_addr_q[RD_LATENCY-1];
                err_data_q <= rddata;
            end
        end
    end

    assign err_addr = err_addr_q;
    assign err_data = err_data_q;
`else
    assign err_addr = '0;
    assign err_data = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign wren      = wren_q;
    assign wraddr    = wraddr_q;
    assign wrdata    = wrdata_q;
    assign rden      = rden_q;
    assign rdaddr    = rdaddr_q;

endmodule

// File: tb/tb_meduram_bist_agent.sv
// Bench for meduram_bist_agent: table of directed runs against a behavioural RAM with
// optional single-bit fault, plus reset-abort and error-counter saturation sequences.
module tb_meduram_bist_agent;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start, start_s;
    logic [31:0] seed;
    logic [7:0]  first_addr, last_addr;

    logic        busy, done, pass, wren, rden;
    logic [15:0] err_count;
    logic [7:0]  err_addr, wraddr, rdaddr;
    logic [31:0] err_data, wrdata, rddata;

    logic        busy_s, done_s, pass_s, wren_s, rden_s;
    logic [3:0]  err_count_s;
    logic [7:0]  err_addr_s, wraddr_s, rdaddr_s;
    logic [31:0] err_data_s, wrdata_s, rddata_s;

    logic        fault_en;
    logic [7:0]  fault_addr;
    logic [31:0] mem   [256];
    logic [31:0] mem_s [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    meduram_bist_agent dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .seed(seed),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_addr(err_addr), .err_data(err_data),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata)
    );

    meduram_bist_agent #(.ERR_WIDTH(4)) dut_s (
        .aclk(aclk), .aresetn(aresetn), .start(start_s), .seed(seed),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
        .err_addr(err_addr_s), .err_data(err_data_s),
        .wren(wren_s), .wraddr(wraddr_s), .wrdata(wrdata_s),
        .rden(rden_s), .rdaddr(rdaddr_s), .rddata(rddata_s)
    );

    // Read latency 1; optional bit-0 flip on one address.
    always @(posedge aclk) begin
        if (wren) mem[wraddr] <= wrdata;
        if (rden) rddata <= mem[rdaddr] ^ {31'd0, (fault_en && rdaddr == fault_addr)};
    end

    // Every read returns inverted data.
    always @(posedge aclk) begin
        if (wren_s) mem_s[wraddr_s] <= wrdata_s;
        if (rden_s) rddata_s <= ~mem_s[rdaddr_s];
    end

    typedef struct {
        logic [7:0]  first;
        logic [7:0]  last;
        logic [31:0] seed;
        bit          fault_en;
        logic [7:0]  fault_addr;
        int          poke_c;
        int          exp_done;
        logic [15:0] exp_errs;
        bit          exp_pass;
        logic [7:0]  chk_addr;
        logic [31:0] chk_wd;
        logic [7:0]  exp_eaddr;
        logic [31:0] exp_edata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          n, seq_bad, done_c;
        logic [7:0]  a;
        logic [31:0] seen_wd;
        logic [63:0] exp_ea, exp_ed;
        n       = int'(8'(v.last - v.first)) + 1;
        seq_bad = 0;
        done_c  = -1;
        seen_wd = 'x;
        fault_en   = v.fault_en;
        fault_addr = v.fault_addr;
        first_addr = v.first;
        last_addr  = v.last;
        seed       = v.seed;
        start      = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int c = 0; c < 1200 && done_c < 0; c++) begin
            if (c < n) begin
                a = v.first + 8'(c);
                if (!wren || rden || wraddr !== a || wrdata !== (v.seed ^ {24'd0, a})) seq_bad++;
                if (wraddr == v.chk_addr) seen_wd = wrdata;
            end else if (c < 2 * n) begin
                a = v.first + 8'(c - n);
                if (wren || !rden || rdaddr !== a) seq_bad++;
            end else if (wren || rden) begin
                seq_bad++;
            end
            if (done) done_c = c;
            else if (!busy) seq_bad++;
            start = (v.poke_c != 0 && c == v.poke_c);
            if (start) seed = 32'h2222_2222;
            @(posedge aclk); #1;
        end
        start = 1'b0;
`ifdef MEDURAM_AGENT_ERRLOG_EN
        exp_ea = 64'(v.exp_eaddr);
        exp_ed = 64'(v.exp_edata);
`else
        exp_ea = 64'd0;
        exp_ed = 64'd0;
`endif
        chk($sformatf("v%0d_sequence_errors", idx), 64'(seq_bad), 64'd0);
        chk($sformatf("v%0d_done_cycle", idx), 64'(done_c), 64'(v.exp_done));
        chk($sformatf("v%0d_wrdata_at_%0h", idx, v.chk_addr), 64'(seen_wd), 64'(v.chk_wd));
        chk($sformatf("v%0d_err_count", idx), 64'(err_count), 64'(v.exp_errs));
        chk($sformatf("v%0d_pass", idx), 64'(pass), 64'(v.exp_pass));
        chk($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d_err_addr", idx), 64'(err_addr), exp_ea);
        chk($sformatf("v%0d_err_data", idx), 64'(err_data), exp_ed);
        repeat (3) @(posedge aclk);
        #1;
        chk($sformatf("v%0d_done_held", idx), 64'({done, busy, wren, rden}), 64'b1000);
        chk($sformatf("v%0d_err_count_held", idx), 64'(err_count), 64'(v.exp_errs));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        //         first   last   seed          flt   faddr  poke done errs    pass chk    chk_wd        eaddr  edata
        vecs[0] = '{8'h00, 8'hFF, 32'hA5A5A5A5, 1'b0, 8'h00, 0,  514, 16'd0, 1'b1, 8'h10, 32'hA5A5A5B5, 8'h00, 32'h00000000};
        vecs[1] = '{8'hFE, 8'h01, 32'h00000000, 1'b0, 8'h00, 0,  10,  16'd0, 1'b1, 8'hFF, 32'h000000FF, 8'h00, 32'h00000000};
        vecs[2] = '{8'h00, 8'h1F, 32'h12345678, 1'b1, 8'h10, 0,  66,  16'd1, 1'b0, 8'h10, 32'h12345668, 8'h10, 32'h12345669};
        vecs[3] = '{8'h20, 8'h2F, 32'hDEADBEEF, 1'b0, 8'h00, 0,  34,  16'd0, 1'b1, 8'h2A, 32'hDEADBEC5, 8'h00, 32'h00000000};
        vecs[4] = '{8'h40, 8'h40, 32'h00000001, 1'b0, 8'h00, 0,  4,   16'd0, 1'b1, 8'h40, 32'h00000041, 8'h00, 32'h00000000};
        vecs[5] = '{8'h00, 8'h0F, 32'h11111111, 1'b0, 8'h00, 3,  34,  16'd0, 1'b1, 8'h05, 32'h11111114, 8'h00, 32'h00000000};
        vecs[6] = '{8'h80, 8'h8F, 32'hCAFEF00D, 1'b0, 8'h00, 20, 34,  16'd0, 1'b1, 8'h8C, 32'hCAFEF081, 8'h00, 32'h00000000};

        aresetn = 1'b0;
        start = 1'b0; start_s = 1'b0;
        seed = 32'h0; first_addr = 8'h0; last_addr = 8'h0;
        fault_en = 1'b0; fault_addr = 8'h0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_ctrl", 64'({busy, done, pass, wren, rden}), 64'd0);
        chk("reset_addr", 64'({wraddr, rdaddr, err_addr}), 64'd0);
        chk("reset_data", 64'({wrdata, err_data}), 64'd0);
        chk("reset_err_count", 64'(err_count), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Abort during the write phase, then a clean run over 0x20..0x2F.
        first_addr = 8'h00; last_addr = 8'hFF; seed = 32'h0000_0005;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        chk("rstmid_write5", 64'({wren, wraddr}), 64'({1'b1, 8'h05}));
        aresetn = 1'b0;
        #1;
        chk("rstmid_ctrl", 64'({busy, done, pass, wren, rden}), 64'd0);
        chk("rstmid_addr_data", 64'({wraddr, rdaddr, wrdata}), 64'd0);
        bad = 1'b0;
        repeat (3) begin
            @(posedge aclk); #1;
            if (wren || rden || busy) bad = 1'b1;
        end
        aresetn = 1'b1;
        repeat (3) begin
            @(posedge aclk); #1;
            if (wren || rden || busy) bad = 1'b1;
        end
        chk("rstmid_no_access", 64'(bad), 64'd0);
        run_vec(7, vecs[3]);

        // Saturation on the 4-bit counter instance.
        first_addr = 8'h00; last_addr = 8'hFF; seed = 32'hA5A5A5A5;
        start_s = 1'b1;
        @(posedge aclk); #1;
        start_s = 1'b0;
        for (int k = 0; k < 2000 && !done_s; k++) begin
            @(posedge aclk); #1;
        end
        chk("sat_done", 64'(done_s), 64'd1);
        chk("sat_err_count", 64'(err_count_s), 64'hF);
        chk("sat_pass", 64'(pass_s), 64'd0);
`ifdef MEDURAM_AGENT_ERRLOG_EN
        chk("sat_err_log", 64'({err_addr_s, err_data_s}), 64'({8'h00, 32'h5A5A5A5A}));
`else
        chk("sat_err_log", 64'({err_addr_s, err_data_s}), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
